// File: rtl/branch_pkg.sv
// Shared definitions for the branch / fetch-PC slice.
//   addr_mode_t : target-select encoding driven on branch_pc_unit.addr_mode
//   InstrStep   : byte distance between sequential instructions
package branch_pkg;

  typedef enum logic [1:0] {
    PC  = 2'd0,  // pc_in + imm
    RD  = 2'd1,  // (rs1d + imm) with bit 0 cleared
    RET = 2'd2,  // return-address-stack top
    SEQ = 2'd3   // pc_in + InstrStep
  } addr_mode_t;

  localparam int unsigned InstrStep = 4;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack.
//   clk, rst   : clock, synchronous active-high reset (pointer and count only)
//   push       : write push_data as the new top
//   pop        : discard the top entry (no effect when empty)
//   push_data  : address written on push
//   top        : current top entry (undefined content when empty)
//   count      : number of valid entries, 0..RasDepth
//   empty/full : count == 0 / count == RasDepth
module return_addr_stack
  import branch_pkg::*;
#(
  parameter int unsigned WordSize = 32,
  parameter int unsigned RasDepth = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WordSize-1:0]         push_data,
  output logic [WordSize-1:0]         top,
  output logic [$clog2(RasDepth):0]   count,
  output logic                        empty,
  output logic                        full
);

  localparam int unsigned PtrW = $clog2(RasDepth);
  localparam int unsigned CntW = PtrW + 1;

  logic [WordSize-1:0] mem_q [RasDepth];
  logic [PtrW-1:0]     ptr_q, ptr_d;     // next slot to write; top is ptr_q-1
  logic [CntW-1:0]     count_q, count_d;
  logic                wr_en;
  logic [PtrW-1:0]     wr_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(RasDepth));
  assign count = count_q;
  assign top   = mem_q[ptr_q - 1'b1];

  // When full, ptr_q already addresses the oldest entry, so a plain push
  // overwrites it while the count saturates.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (push && pop && !empty) begin
      // Replace the top in place: pointer and count unchanged.
      wr_en  = 1'b1;
      wr_idx = ptr_q - 1'b1;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents are never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch target generation and fetch-PC sequencing with a return-address stack.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : hold fetch PC when no redirect
//   br_valid        : resolved control-flow instruction present
//   addr_mode       : target select (see branch_pkg::addr_mode_t)
//   branch_taken    : condition outcome (qualified by br_valid)
//   ras_push        : instruction is a call (qualified by br_valid)
//   imm, rs1d, pc_in: immediate, source register, PC of resolving instruction
//   branch_addr     : combinational target
//   link_addr       : combinational pc_in + 4
//   pc              : registered fetch PC
//   flush           : one-cycle pulse after an accepted redirect
//   ras_count       : registered RAS valid-entry count
//   ras_underflow   : one-cycle pulse after a RET pop with empty RAS
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int unsigned          WordSize = 32,
  parameter int unsigned          RasDepth = 4,
  parameter logic [WordSize-1:0]  ResetVec = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       br_valid,
  input  logic [1:0]                 addr_mode,
  input  logic                       branch_taken,
  input  logic                       ras_push,
  input  logic [WordSize-1:0]        imm,
  input  logic [WordSize-1:0]        rs1d,
  input  logic [WordSize-1:0]        pc_in,
  output logic [WordSize-1:0]        branch_addr,
  output logic [WordSize-1:0]        link_addr,
  output logic [WordSize-1:0]        pc,
  output logic                       flush,
  output logic [$clog2(RasDepth):0]  ras_count,
  output logic                       ras_underflow
);

  addr_mode_t           mode;
  logic [WordSize-1:0]  rd_sum;
  logic                 redirect;
  logic                 push_en;
  logic                 pop_en;
  logic [WordSize-1:0]  ras_top;
  logic                 ras_empty;
  logic                 ras_full;

  logic [WordSize-1:0]  pc_q, pc_d;
  logic                 flush_q, flush_d;
  logic                 underflow_q, underflow_d;

  assign mode      = addr_mode_t'(addr_mode);
  assign link_addr = pc_in + WordSize'(InstrStep);
  assign rd_sum    = rs1d + imm;

  always_comb begin
    branch_addr = link_addr;
    unique case (mode)
      PC:      branch_addr = pc_in + imm;
      RD:      branch_addr = {rd_sum[WordSize-1:1], 1'b0};
      RET:     branch_addr = ras_empty ? link_addr : ras_top;
      default: branch_addr = link_addr;
    endcase
  end

  assign redirect = br_valid && branch_taken && (mode != SEQ);
  assign push_en  = br_valid && ras_push;
  assign pop_en   = redirect && (mode == RET);

  always_comb begin
    flush_d     = redirect;
    underflow_d = pop_en && ras_empty;
    if (redirect)   pc_d = branch_addr;
    else if (stall) pc_d = pc_q;
    else            pc_d = pc_q + WordSize'(InstrStep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= ResetVec;
      flush_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      underflow_q <= underflow_d;
    end
  end

  return_addr_stack #(
    .WordSize (WordSize),
    .RasDepth (RasDepth)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .pop       (pop_en),
    .push_data (link_addr),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc            = pc_q;
  assign flush         = flush_q;
  assign ras_underflow = underflow_q;

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter WordSize, default 32: width of all address/data ports.
REQ-002 Parameter RasDepth, default 4: return-address-stack entries, power of two, >=2.
REQ-003 Parameter ResetVec, default 0: fetch PC value after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  hold fetch PC.
REQ-007 br_valid  in  1  resolved control-flow instruction present this cycle.
REQ-008 addr_mode  in  2  target select: PC=0 (pc_in+imm), RD=1 (rs1d+imm), RET=2 (RAS top), SEQ=3 (pc_in+4).
REQ-009 branch_taken  in  1  condition outcome; ignored unless br_valid.
REQ-010 ras_push  in  1  instruction is a call; ignored unless br_valid.
REQ-011 imm, rs1d, pc_in  in  WordSize  immediate, source register, PC of resolving instruction.
REQ-012 branch_addr  out  WordSize  combinational target.
REQ-013 link_addr  out  WordSize  combinational pc_in+4.
REQ-014 pc  out  WordSize  registered fetch PC.
REQ-015 flush  out  1  registered one-cycle pulse following an accepted redirect.
REQ-016 ras_count  out  $clog2(RasDepth)+1  registered valid-entry count.
REQ-017 ras_underflow  out  1  registered one-cycle pulse: RET pop with empty RAS.

Function
REQ-018 branch_addr per addr_mode: PC -> pc_in+imm; RD -> (rs1d+imm) with bit 0 cleared; RET -> RAS top, or pc_in+4 when RAS empty; SEQ -> pc_in+4; all sums modulo 2^WordSize.
REQ-019 Redirect = br_valid & branch_taken & addr_mode!=SEQ.
REQ-020 On redirect, pc <= branch_addr and flush <= 1 next cycle, regardless of stall.
REQ-021 No redirect and stall=0: pc <= pc+4 (wraps at 2^WordSize); stall=1: pc holds; flush <= 0.
REQ-022 Push: br_valid & ras_push -> write pc_in+4 at top; count increments, saturating at RasDepth.
REQ-023 Push when full: overwrite oldest entry (circular pointer); count stays RasDepth.
REQ-024 Pop: redirect with addr_mode=RET -> count decrements; top pointer moves back.
REQ-025 Pop when empty: count stays 0, ras_underflow <= 1 next cycle, target per REQ-018.
REQ-026 Push and pop same cycle: top entry replaced with pc_in+4, count unchanged; if empty, acts as push only, underflow pulse still raised.
REQ-027 RAS updates independent of stall.
REQ-028 Latency: branch_addr/link_addr 0 cycles; pc, flush, RAS state 1 cycle.

Reset
REQ-029 While rst=1 at a clock edge: pc <= ResetVec, flush <= 0, ras_underflow <= 0, ras_count <= 0, RAS pointer <= 0; all other inputs ignored.
REQ-030 Reset mid-operation discards any same-cycle redirect or push; RAS entry contents need not be cleared.

Structure
REQ-031 Shared package branch_pkg holds addr_mode_t enum (PC, RD, RET, SEQ) and the instruction-step constant 4.
REQ-032 RAS implemented as sub-module return_addr_stack (push, pop, top, count, empty, full), parametrised by WordSize and RasDepth.

Verification
REQ-033 Reset then 3 idle cycles, ResetVec=0x100 -> pc 0x100, 0x104, 0x108, 0x10C; flush 0.
REQ-034 br_valid=1, mode PC, taken=1, pc_in=0x200, imm=0xFFFFFFF0, stall=1 -> branch_addr 0x1F0 same cycle; next cycle pc=0x1F0, flush=1, then flush=0.
REQ-035 Mode RD, rs1d=0x1001, imm=0x4, taken=1 -> branch_addr 0x1004; pc=0x1004 next cycle.
REQ-036 Five calls (RasDepth=4) with pc_in 0x10,0x20,0x30,0x40,0x50, then five RET pops -> targets 0x54,0x44,0x34,0x24, then fallback pc_in+4 with ras_underflow=1; ras_count 4,3,2,1,0,0.
REQ-037 Same-cycle push+pop, ras_count=2, pc_in=0x80 -> top becomes 0x84, count stays 2.
REQ-038 rst asserted during a taken-branch cycle -> pc=ResetVec, ras_count=0, flush=0 next cycle.
